// File: rtl/lod_expand_pkg.sv
// Shared definitions for the leading-one normalize/expand pair.
// Holds the default magnitude width, the derived position width and the
// FSM state encoding, so both sides of the log-domain path agree.
package lod_expand_pkg;

   localparam int unsigned LE_N  = 16;
   localparam int unsigned LE_KW = $clog2(LE_N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } le_state_e;

endpackage

// File: rtl/lod_expand.sv
// Serial leading-one expander: rebuilds {1'b1, frac} >> (N-1-k), one bit
// shift per cycle, as the inverse of the leading-one normalize step.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (ready only while idle)
//   in_k              bit index of the leading one (0 = LSB)
//   in_frac           bits below the leading one, MSB-aligned
//   in_zero           magnitude is zero; in_k/in_frac ignored
//   out_valid/ready   result handshake
//   out_data          reconstructed unsigned magnitude (truncated)
module lod_expand
   import lod_expand_pkg::*;
#(
   parameter int unsigned N  = LE_N,
   parameter int unsigned KW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [KW-1:0] in_k,
   input  logic [N-2:0]  in_frac,
   input  logic          in_zero,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data
);

   le_state_e     state_q, state_d;
   logic [N-1:0]  sreg_q, sreg_d;
   logic [KW-1:0] cnt_q, cnt_d;
   logic          out_valid_q;
   logic          in_ready_q;
   logic [KW-1:0] k_eff;
   logic [KW-1:0] cnt_load;

   // Clamp k to N-1 (only reachable when N is not a power of two).
   always_comb begin
      k_eff    = (in_k > KW'(N-1)) ? KW'(N-1) : in_k;
      cnt_load = in_zero ? '0 : (KW'(N-1) - k_eff);
   end

   // Next-state, shifter and counter.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               sreg_d  = in_zero ? '0 : {1'b1, in_frac};
               cnt_d   = cnt_load;
               state_d = (cnt_load == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Zero-fill truncation: bits leaving the LSB are dropped.
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q - KW'(1);
            if (cnt_q == KW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; handshake flags decoded from next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         out_valid_q <= (state_d == DONE);
         in_ready_q  <= (state_d == IDLE);
      end
   end

   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign out_data  = sreg_q;

endmodule

// File: tb/tb_lod_expand.sv
// Scoreboard bench for lod_expand: directed cases, backpressure, reset
// abort, random expansions and leading-one round trips.
module tb_lod_expand;
   import lod_expand_pkg::*;

   localparam int unsigned N  = LE_N;
   localparam int unsigned KW = LE_KW;
   localparam int unsigned FW = N - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [KW-1:0] in_k;
   logic [FW-1:0] in_frac;
   logic          in_zero;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;

   lod_expand #(.N(N), .KW(KW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_k      (in_k),
      .in_frac   (in_frac),
      .in_zero   (in_zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] data;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   last_hs  = -10;
   int   rdy_mode = 2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: linear value of a leading one at k with frac bits below it.
   function automatic logic [N-1:0] model(input int k, input int frac, input bit zero);
      int ke;
      int mag;
      ke  = (k > int'(N - 1)) ? int'(N - 1) : k;
      mag = (1 << (N - 1)) | frac;
      if (zero) return '0;
      return N'(mag / (1 << (int'(N - 1) - ke)));
   endfunction

   // Reference leading-one detector: position of highest set bit.
   function automatic int lod_pos(input int x);
      int p;
      p = 0;
      for (int i = 0; i < int'(N); i++) begin
         if (((x >> i) & 1) != 0) p = i;
      end
      return p;
   endfunction

   task automatic submit(input int k, input int frac, input bit zero,
                         input logic [N-1:0] expd, output int acc);
      int w;
      int ke;
      w  = 0;
      ke = (k > int'(N - 1)) ? int'(N - 1) : k;
      @(negedge clk);
      in_k     = KW'(k);
      in_frac  = FW'(frac);
      in_zero  = zero;
      in_valid = 1'b1;
      while (!in_ready) begin
         @(negedge clk);
         w++;
         if (w > 200) begin
            checks++;
            errors++;
            $display("FAIL submit_timeout: in_ready stuck at 0 for k=%0d", k);
            in_valid = 1'b0;
            acc = -1;
            return;
         end
      end
      acc = cyc + 1;
      sb.push_back('{data: expd, lat: (zero ? 1 : int'(N) - ke), acc: acc});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Consumer-side ready generation.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compares every valid cycle against the scoreboard head.
   initial begin
      bit seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            seen = 1'b0;
            continue;
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: out_valid=1 data=0x%0h with no request pending", out_data);
            end else begin
               if (!seen) begin
                  chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
                  seen = 1'b1;
               end
               chk("out_data", out_data, sb[0].data);
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen    = 1'b0;
                  last_hs = cyc + 1;
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int a2;
      int x;
      int k;
      int fr;
      bit z;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_k     = '0;
      in_frac  = '0;
      in_zero  = 1'b0;
      rdy_mode = 2;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_data", out_data, 0);
      rst = 1'b0;

      // Directed corner cases.
      submit(15, 'h0000, 1'b0, 16'h8000, a);
      submit(0,  'h7FFF, 1'b0, 16'h0001, a);
      submit(7,  'h5000, 1'b0, 16'h00D0, a);
      submit(3,  'h1234, 1'b1, 16'h0000, a);
      drain();

      // Backpressure with a second request held during busy.
      rdy_mode = 1;
      submit(15, 'h0000, 1'b0, 16'h8000, a);
      fork
         begin
            submit(2, 'h0000, 1'b0, 16'h0004, a2);
            chk("reaccept_cycle", a2, last_hs + 1);
         end
         begin
            repeat (5) begin
               @(negedge clk);
               #2;
               chk("busy_in_ready", in_ready, 0);
               chk("held_data", out_data, 16'h8000);
            end
            rdy_mode = 2;
         end
      join
      drain();

      // Reset in the middle of a long shift.
      submit(0, 'h7FFF, 1'b0, 16'h0001, a);
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_data", out_data, 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      #2;
      chk("no_stale_result", out_valid, 0);

      // Random expansions with random backpressure.
      rdy_mode = 0;
      for (int i = 0; i < 300; i++) begin
         k  = $urandom_range(0, N - 1);
         fr = $urandom_range(0, (1 << FW) - 1);
         z  = ($urandom_range(0, 7) == 0);
         submit(k, fr, z, model(k, fr, z), a);
      end
      drain();

      // Round trip through a leading-one decomposition.
      for (int i = 0; i < 1000; i++) begin
         x  = $urandom_range(1, (1 << N) - 1);
         k  = lod_pos(x);
         fr = (x << (int'(N - 1) - k)) & ((1 << FW) - 1);
         submit(k, fr, 1'b0, N'(x), a);
      end
      drain();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
